// File: rtl/l2_result_sink_if.sv
// Result-stream and readback bundle for the L2 result sink.
// Ports: accumulator side (f_in, f_valid, ovf_in), host side (clear_stats,
// rd_en, rd_data, rd_valid), status (empty, full, count, drop_count,
// sticky_ovf, wrap_err). master = producer/reader, slave = the sink.
interface l2_result_sink_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 20
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] f_in;
    logic             f_valid;
    logic             ovf_in;
    logic             clear_stats;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic [7:0]       drop_count;
    logic             sticky_ovf;
    logic             wrap_err;

    modport master (
        output f_in, f_valid, ovf_in, clear_stats, rd_en,
        input  rd_data, rd_valid, empty, full, count,
        input  drop_count, sticky_ovf, wrap_err
    );

    modport slave (
        input  f_in, f_valid, ovf_in, clear_stats, rd_en,
        output rd_data, rd_valid, empty, full, count,
        output drop_count, sticky_ovf, wrap_err
    );
endinterface

// File: rtl/l2_result_sink.sv
// Captures accumulator results into a small FIFO and tracks integrity stats.
// Ports: clk, reset (sync, active-high), sif (l2_result_sink_if.slave).
module l2_result_sink #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 20
) (
    input logic clk,
    input logic reset,
    l2_result_sink_if.slave sif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic [7:0]       drop_q, drop_d;
    logic             sovf_q, sovf_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] last_f_q, last_f_d;

    logic empty, full, wr_en, rd_go;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    // Full is the pre-edge value: a same-cycle read never frees room.
    assign wr_en = sif.f_valid && !full;
    assign rd_go = sif.rd_en && !empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        drop_d     = drop_q;
        sovf_d     = sovf_q;
        wrap_d     = wrap_q;
        last_f_d   = last_f_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_go) begin
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + PW'(1);
        end

        unique case ({wr_en, rd_go})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Clear beats any same-cycle stat event, including the last_f update.
        if (sif.clear_stats) begin
            drop_d   = '0;
            sovf_d   = 1'b0;
            wrap_d   = 1'b0;
            last_f_d = '0;
        end else begin
            if (sif.f_valid && full && drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
            if (sif.ovf_in) begin
                sovf_d = 1'b1;
            end
            // Dropped samples still feed the monotonic check.
            if (sif.f_valid) begin
                if (sif.f_in < last_f_q) begin
                    wrap_d = 1'b1;
                end
                last_f_d = sif.f_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= sif.f_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            drop_q     <= '0;
            sovf_q     <= 1'b0;
            wrap_q     <= 1'b0;
            last_f_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            drop_q     <= drop_d;
            sovf_q     <= sovf_d;
            wrap_q     <= wrap_d;
            last_f_q   <= last_f_d;
        end
    end

    assign sif.rd_data    = rd_data_q;
    assign sif.rd_valid   = rd_valid_q;
    assign sif.empty      = empty;
    assign sif.full       = full;
    assign sif.count      = count_q;
    assign sif.drop_count = drop_q;
    assign sif.sticky_ovf = sovf_q;
    assign sif.wrap_err   = wrap_q;
endmodule

// File: doc/l2_result_sink.md
# l2_result_sink

Capture block on the output side of the L2 accumulator (`part2`). It consumes the accumulator's result stream (`f`, `valid_out`, `overflow`) and buffers accepted results in a small FIFO for a downstream reader. It also keeps result-integrity statistics: dropped samples, a sticky overflow flag, and a wrap-around (non-monotonic result) detector. It sits between the accumulator and any host or readback logic.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `WIDTH`, 20, result width; matches accumulator `f`
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`
- `f_in`  in  WIDTH  accumulator result
- `f_valid`  in  1  `f_in` is valid this cycle; driven from accumulator `valid_out`
- `ovf_in`  in  1  accumulator overflow indication
- `clear_stats`  in  1  synchronous clear of statistics only
- `rd_en`  in  1  read request
- `rd_data`  out  WIDTH  read result; registered
- `rd_valid`  out  1  `rd_data` is valid; one-cycle pulse
- `empty`  out  1  FIFO holds 0 entries
- `full`  out  1  FIFO holds DEPTH entries
- `count`  out  $clog2(DEPTH)+1  current occupancy
- `drop_count`  out  8  results lost while full; saturates at 255
- `sticky_ovf`  out  1  `ovf_in` has been seen high since last clear
- `wrap_err`  out  1  a result smaller than its predecessor has been seen since last clear

## Operation
- Storage: circular FIFO with write pointer, read pointer and occupancy counter. Pointers wrap modulo DEPTH.
- Write: on a cycle with `f_valid=1` and `full=0`, `f_in` is stored at the write pointer and the write pointer increments.
- Full:
  - When `f_valid=1` and `full=1`, the sample is dropped.
  - `drop_count` increments and holds at 255.
  - `full` is the registered pre-edge value, so a read in the same cycle does not make room for that write.
- Read:
  - On a cycle with `rd_en=1` and `empty=0`, the entry at the read pointer is loaded into `rd_data`, `rd_valid` is set for one cycle, and the read pointer increments.
  - `rd_en` while empty is ignored: `rd_valid=0` and `rd_data` holds.
- Simultaneous accepted read and write: `count` is unchanged.
- Monotonic check:
  - A `last_f` register (reset 0) is compared on every `f_valid` cycle, whether the sample is accepted or dropped.
  - If `f_in < last_f`, `wrap_err` is set (sticky).
  - `last_f` is then updated to `f_in`.
- Overflow: `ovf_in=1` on any cycle sets `sticky_ovf` (sticky), regardless of `f_valid`.
- `clear_stats`:
  - Zeroes `drop_count`, `sticky_ovf`, `wrap_err` and `last_f`.
  - FIFO contents and pointers are untouched.
  - If a set or increment event occurs in the same cycle, clear wins and the event is lost.
  - The `last_f` update is also suppressed that cycle.
- `reset` (highest priority, any cycle, including mid-stream): pointers, `count`, statistics, `last_f`, `rd_data` and `rd_valid` go to 0, and `empty` goes to 1.

## Timing
- Reset values: `rd_data=0`, `rd_valid=0`, `empty=1`, `full=0`, `count=0`, `drop_count=0`, `sticky_ovf=0`, `wrap_err=0`.
- Write to visibility: `count`, `empty` and `full` update on the edge that accepts the write, so they are valid the following cycle.
- Read latency: 1 cycle. `rd_en` is sampled at edge N; `rd_data` and `rd_valid` are valid after edge N, for one cycle.
- Back-to-back reads every cycle return consecutive entries with no bubbles.
- Write then read in consecutive cycles: an entry written at edge N can be read with `rd_en` sampled at edge N+1, returning data after edge N+1.
- Flags derive from registered `count`: `empty=(count==0)`, `full=(count==DEPTH)`. Both are registered or equivalently stable for the whole cycle.
- There is no backpressure to the accumulator. `f_valid` may be high on every cycle.

## Test plan
- **Reset and idle:** hold `reset` for 2 cycles, then release → all outputs at their reset values. `rd_en=1` while empty → `rd_valid` stays 0 and `rd_data` stays 0.
- **Ordered capture:**
  - Stream `f_in` = 1, 5, 14, 30 with `f_valid` gaps of 0, 2 and 1 cycles → `count=4`.
  - Read 4 back-to-back → `rd_data` = 1, 5, 14, 30 on consecutive cycles, each with `rd_valid=1`, then `empty=1`.
- **Full and drop:**
  - Write 10 increasing samples with DEPTH=8 → `full=1` after the 8th write and `drop_count=2`.
  - Read all 8 → the first 8 values are returned.
  - Write and read on the same cycle while full → the write is dropped and `drop_count=3`.
- **Wrap-around:**
  - `f_in` = 0xFFFF0, then 0x00010 → `wrap_err=1`; both samples are stored.
  - `clear_stats` pulse → `wrap_err=0`.
  - Next sample 0x00005 → no error, because `last_f` was cleared.
- **Overflow sticky:** one-cycle `ovf_in=1` with `f_valid=0` → `sticky_ovf=1` and it stays set across 20 cycles until `clear_stats`.
- **Reset mid-operation:** fill 5 entries, set `wrap_err`, then issue `reset` on the same cycle as `rd_en` → all outputs return to reset values, `rd_valid=0`, and a subsequent write/read returns only the new data.
